// File: rtl/stream_upsize_pkg.sv
// ---------------------------------------------------------------------------
// stream_upsize_pkg
// Shared definitions for the stream upsizer (packer side and the
// parallel-out fifo side).
//   IN_WIDTH_DEF / RATIO_DEF : default narrow beat width and beats per word
//   lane_idx_w(ratio)        : width of a lane index for a given ratio
//   keep_mask(cnt)           : keep mask with lanes 0..cnt set
//   lane_idx_t               : lane index type for the default ratio
// ---------------------------------------------------------------------------
package stream_upsize_pkg;

   localparam int unsigned IN_WIDTH_DEF = 8;
   localparam int unsigned RATIO_DEF    = 4;

   function automatic int unsigned lane_idx_w(input int unsigned ratio);
      return (ratio > 1) ? $clog2(ratio) : 1;
   endfunction

   // (2<<cnt)-1: the last captured lane is cnt, so lanes 0..cnt are valid
   function automatic logic [31:0] keep_mask(input int unsigned cnt);
      return (32'd2 << cnt) - 32'd1;
   endfunction

   typedef logic [lane_idx_w(RATIO_DEF)-1:0] lane_idx_t;

endpackage

// File: rtl/stream_upsize_packer_out_reg.sv
// ---------------------------------------------------------------------------
// upsize_out_reg
// Wide output holding register of the stream upsizer. A word loaded via
// load_i is presented on the m_* interface and held stable until accepted.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   load_i         : load data_i/keep_i/last_i (only asserted when free or
//                    being drained in the same cycle)
//   data_i, keep_i, last_i : word to load
//   m_tready_i     : downstream ready
//   m_tvalid_o, m_tdata_o, m_tkeep_o, m_tlast_o : registered wide stream
// ---------------------------------------------------------------------------
module upsize_out_reg #(
   parameter int unsigned OUT_WIDTH = 32,
   parameter int unsigned RATIO     = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 load_i,
   input  logic [OUT_WIDTH-1:0] data_i,
   input  logic [RATIO-1:0]     keep_i,
   input  logic                 last_i,
   input  logic                 m_tready_i,
   output logic                 m_tvalid_o,
   output logic [OUT_WIDTH-1:0] m_tdata_o,
   output logic [RATIO-1:0]     m_tkeep_o,
   output logic                 m_tlast_o
);

   logic                 valid_q, valid_d;
   logic [OUT_WIDTH-1:0] data_q, data_d;
   logic [RATIO-1:0]     keep_q, keep_d;
   logic                 last_q, last_d;

   // A load during a drain replaces the word without dropping valid
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      keep_d  = keep_q;
      last_d  = last_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
         keep_d  = keep_i;
         last_d  = last_i;
      end else if (valid_q && m_tready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         keep_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         keep_q  <= keep_d;
         last_q  <= last_d;
      end
   end

   assign m_tvalid_o = valid_q;
   assign m_tdata_o  = data_q;
   assign m_tkeep_o  = keep_q;
   assign m_tlast_o  = last_q;

endmodule

// File: rtl/stream_upsize_packer.sv
// ---------------------------------------------------------------------------
// stream_upsize_packer
// Packs RATIO narrow beats (fewer if tlast arrives early) into one wide
// word, lane 0 first, presented from a registered holding stage.
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   s_tvalid_i/s_tready_o/s_tdata_i/s_tlast_i : narrow input stream
//   m_tvalid_o/m_tready_i/m_tdata_o/m_tkeep_o/m_tlast_o : wide output stream
//   pkt_cnt_o [15:0]             : accepted packet-ending words (only when
//                                  UPSIZE_PKT_CNT_EN is defined)
// Optional feature macro: UPSIZE_PKT_CNT_EN
// ---------------------------------------------------------------------------
module stream_upsize_packer
   import stream_upsize_pkg::*;
#(
   parameter int unsigned IN_WIDTH = IN_WIDTH_DEF,
   parameter int unsigned RATIO    = RATIO_DEF
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      s_tvalid_i,
   output logic                      s_tready_o,
   input  logic [IN_WIDTH-1:0]       s_tdata_i,
   input  logic                      s_tlast_i,
   output logic                      m_tvalid_o,
   input  logic                      m_tready_i,
   output logic [IN_WIDTH*RATIO-1:0] m_tdata_o,
   output logic [RATIO-1:0]          m_tkeep_o,
   output logic                      m_tlast_o
`ifdef UPSIZE_PKT_CNT_EN
   ,
   output logic [15:0]               pkt_cnt_o
`endif
);

   localparam int unsigned OUT_WIDTH = IN_WIDTH * RATIO;
   localparam int unsigned IDX_W     = lane_idx_w(RATIO);
   localparam logic [IDX_W-1:0] CNT_MAX = IDX_W'(RATIO - 1);

   logic [IDX_W-1:0]     cnt_q, cnt_d;
   logic [OUT_WIDTH-1:0] acc_q, acc_d;
   logic                 s_accept;
   logic                 complete;
   logic [OUT_WIDTH-1:0] ld_data;
   logic [RATIO-1:0]     ld_keep;

   // Ready only depends on the holding stage being free or draining now
   assign s_tready_o = ~rst_i & (~m_tvalid_o | m_tready_i);

   always_comb begin
      s_accept = s_tvalid_i & s_tready_o;
      complete = s_accept & ((cnt_q == CNT_MAX) | s_tlast_i);

      // Accumulator with the current beat merged into lane cnt; lanes above
      // cnt are still zero because acc is cleared on every completion.
      ld_data = acc_q;
      for (int k = 0; k < int'(RATIO); k++) begin
         if (cnt_q == IDX_W'(k)) begin
            ld_data[k*IN_WIDTH +: IN_WIDTH] = s_tdata_i;
         end
      end
      ld_keep = RATIO'(keep_mask(32'(cnt_q)));

      cnt_d = cnt_q;
      acc_d = acc_q;
      if (complete) begin
         cnt_d = '0;
         acc_d = '0;
      end else if (s_accept) begin
         cnt_d = cnt_q + 1'b1;
         acc_d = ld_data;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         acc_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         acc_q <= acc_d;
      end
   end

   upsize_out_reg #(
      .OUT_WIDTH (OUT_WIDTH),
      .RATIO     (RATIO)
   ) u_out_reg (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (complete),
      .data_i     (ld_data),
      .keep_i     (ld_keep),
      .last_i     (s_tlast_i),
      .m_tready_i (m_tready_i),
      .m_tvalid_o (m_tvalid_o),
      .m_tdata_o  (m_tdata_o),
      .m_tkeep_o  (m_tkeep_o),
      .m_tlast_o  (m_tlast_o)
   );

`ifdef UPSIZE_PKT_CNT_EN
   logic [15:0] pkt_cnt_q, pkt_cnt_d;

   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      if (m_tvalid_o && m_tready_i && m_tlast_o) begin
         pkt_cnt_d = pkt_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pkt_cnt_q <= '0;
      end else begin
         pkt_cnt_q <= pkt_cnt_d;
      end
   end

   assign pkt_cnt_o = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_stream_upsize_packer.sv
// ---------------------------------------------------------------------------
// tb_stream_upsize_packer
// Directed scenarios plus randomized traffic for stream_upsize_packer
// (IN_WIDTH=8, RATIO=4), checked against a packet-level reference model.
// ---------------------------------------------------------------------------
module tb_stream_upsize_packer;

   localparam int IW = 8;
   localparam int R  = 4;
   localparam int OW = IW * R;

   typedef struct {
      logic [OW-1:0] data;
      logic [R-1:0]  keep;
      logic          last;
   } word_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          s_tvalid = 1'b0;
   logic          s_tready;
   logic [IW-1:0] s_tdata = '0;
   logic          s_tlast = 1'b0;
   logic          m_tvalid;
   logic          m_tready;
   logic [OW-1:0] m_tdata;
   logic [R-1:0]  m_tkeep;
   logic          m_tlast;
`ifdef UPSIZE_PKT_CNT_EN
   logic [15:0]   pkt_cnt;
`endif

   logic rand_mode = 1'b0;
   logic rdy_dir   = 1'b1;
   logic rdy_rand  = 1'b1;
   assign m_tready = rand_mode ? rdy_rand : rdy_dir;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int words_seen = 0;

   stream_upsize_packer dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .s_tvalid_i (s_tvalid),
      .s_tready_o (s_tready),
      .s_tdata_i  (s_tdata),
      .s_tlast_i  (s_tlast),
      .m_tvalid_o (m_tvalid),
      .m_tready_i (m_tready),
      .m_tdata_o  (m_tdata),
      .m_tkeep_o  (m_tkeep),
      .m_tlast_o  (m_tlast)
`ifdef UPSIZE_PKT_CNT_EN
      ,
      .pkt_cnt_o  (pkt_cnt)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc++;
      #1;
      rdy_rand = ($urandom_range(0, 2) != 0);
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Collects accepted beats into a packet-level word; a word is closed
   // after RATIO beats or at tlast and queued for comparison.
   word_t         exp_q[$];
   logic [OW-1:0] b_data = '0;
   int            b_cnt  = 0;
   logic          hold_prev = 1'b0;
   logic [63:0]   hold_val  = '0;

   always @(negedge clk) begin
      word_t w;
      check_val("s_tready_rule", {63'd0, s_tready}, {63'd0, ~rst & (~m_tvalid | m_tready)});
      if (rst) begin
         exp_q.delete();
         b_data    = '0;
         b_cnt     = 0;
         hold_prev = 1'b0;
      end else begin
         if (hold_prev) begin
            check_val("hold_stable", {26'd0, m_tvalid, m_tlast, m_tkeep, m_tdata}, hold_val);
         end
         hold_prev = m_tvalid & ~m_tready;
         hold_val  = {26'd0, m_tvalid, m_tlast, m_tkeep, m_tdata};
         if (m_tvalid && m_tready) begin
            words_seen++;
            if (exp_q.size() == 0) begin
               check_val("unexpected_word", {32'd0, m_tdata}, 64'd0);
            end else begin
               w = exp_q.pop_front();
               check_val("sb_data", {32'd0, m_tdata}, {32'd0, w.data});
               check_val("sb_keep", {60'd0, m_tkeep}, {60'd0, w.keep});
               check_val("sb_last", {63'd0, m_tlast}, {63'd0, w.last});
            end
         end
         if (s_tvalid && s_tready) begin
            b_data[b_cnt*IW +: IW] = s_tdata;
            b_cnt++;
            if (b_cnt == R || s_tlast) begin
               w.data = b_data;
               w.keep = R'((1 << b_cnt) - 1);
               w.last = s_tlast;
               exp_q.push_back(w);
               b_data = '0;
               b_cnt  = 0;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic [IW-1:0] d, input logic l);
      int n;
      n = 0;
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tlast  = l;
      forever begin
         @(negedge clk);
         if (s_tready) break;
         n++;
         if (n > 200) begin
            check_val("send_timeout", 64'd1, 64'd0);
            break;
         end
      end
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int t0;
      int w0;
      do_reset(3);
      check_val("rst_valid", {63'd0, m_tvalid}, 64'd0);
      check_val("rst_data",  {32'd0, m_tdata},  64'd0);
      check_val("rst_keep",  {60'd0, m_tkeep},  64'd0);
      check_val("rst_last",  {63'd0, m_tlast},  64'd0);

      // 1. full word
      rdy_dir = 1'b1;
      send(8'h11, 1'b0);
      send(8'h22, 1'b0);
      send(8'h33, 1'b0);
      check_val("s1_not_yet", {63'd0, m_tvalid}, 64'd0);
      send(8'h44, 1'b0);
      check_val("s1_valid", {63'd0, m_tvalid}, 64'd1);
      check_val("s1_data",  {32'd0, m_tdata}, 64'h44332211);
      check_val("s1_keep",  {60'd0, m_tkeep}, 64'hF);
      check_val("s1_last",  {63'd0, m_tlast}, 64'd0);

      // 2. early last, then next packet restarts in lane 0
      send(8'hAA, 1'b0);
      send(8'hBB, 1'b1);
      check_val("s2_data", {32'd0, m_tdata}, 64'h0000BBAA);
      check_val("s2_keep", {60'd0, m_tkeep}, 64'h3);
      check_val("s2_last", {63'd0, m_tlast}, 64'd1);
      send(8'hCC, 1'b1);
      check_val("s2_lane0_data", {32'd0, m_tdata}, 64'h000000CC);
      check_val("s2_lane0_keep", {60'd0, m_tkeep}, 64'h1);
      check_val("s2_lane0_last", {63'd0, m_tlast}, 64'd1);
      idle(2);

      // 3. backpressure
      rdy_dir = 1'b0;
      send(8'h31, 1'b0);
      send(8'h32, 1'b0);
      send(8'h33, 1'b0);
      send(8'h34, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_val("s3_tready_low", {63'd0, s_tready}, 64'd0);
         check_val("s3_data_hold", {32'd0, m_tdata}, 64'h34333231);
      end
      @(posedge clk);
      #1;
      rdy_dir = 1'b1;
      @(negedge clk);
      check_val("s3_release_tready", {63'd0, s_tready}, 64'd1);
      @(posedge clk);
      #1;
      check_val("s3_drained", {63'd0, m_tvalid}, 64'd0);

      // 4. streaming without bubbles
      t0 = cyc;
      w0 = words_seen;
      for (int i = 1; i <= 8; i++) send(IW'(i), 1'b0);
      check_val("s4_cycles", 64'(cyc - t0), 64'd8);
      check_val("s4_word2", {32'd0, m_tdata}, 64'h08070605);
      check_val("s4_word1_seen", 64'(words_seen - w0), 64'd1);
      idle(2);

      // 5. reset mid-fill
      send(8'hE1, 1'b0);
      send(8'hE2, 1'b0);
      do_reset(1);
      check_val("s5_no_word", {63'd0, m_tvalid}, 64'd0);
      check_val("s5_data_clr", {32'd0, m_tdata}, 64'd0);
      send(8'h5A, 1'b0);
      send(8'h5B, 1'b0);
      send(8'h5C, 1'b0);
      send(8'h5D, 1'b0);
      check_val("s5_data", {32'd0, m_tdata}, 64'h5D5C5B5A);
      check_val("s5_keep", {60'd0, m_tkeep}, 64'hF);
      idle(2);

      // randomized traffic
      rand_mode = 1'b1;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) idle(1);
         send(IW'($urandom), ($urandom_range(0, 5) == 0));
      end
      rand_mode = 1'b0;
      rdy_dir   = 1'b1;
      send(8'hF0, 1'b1);
      idle(5);
      check_val("rand_leftover", 64'(exp_q.size()), 64'd0);

`ifdef UPSIZE_PKT_CNT_EN
      // 6. packet counter
      do_reset(1);
      check_val("s6_cnt_rst", {48'd0, pkt_cnt}, 64'd0);
      w0 = words_seen;
      send(8'h01, 1'b1);
      for (int i = 0; i < 4; i++) send(IW'(8'h10 + i), (i == 3));
      for (int i = 0; i < 6; i++) send(IW'(8'h20 + i), (i == 5));
      idle(4);
      check_val("s6_words", 64'(words_seen - w0), 64'd4);
      check_val("s6_pkt_cnt", {48'd0, pkt_cnt}, 64'd3);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
